// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision mantissa/product widths and the
// state encoding of the iterative mantissa multiplier.
package fpu_pkg;

  localparam int SP_MANT_W = 24;
  localparam int SP_PROD_W = 2 * SP_MANT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_seq_state_e;

endpackage

// File: rtl/fpu_mul_pp_step.sv
// One shift-add step of the mantissa multiplier: hi + a * digit, where the
// digit is the low BPC bits of the multiplier. The result is exact in WIDTH+BPC bits.
module fpu_mul_pp_step #(
  parameter int WIDTH = 24,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0]     hi,
  input  logic [WIDTH-1:0]     a,
  input  logic [BPC-1:0]       digit,
  output logic [WIDTH+BPC-1:0] sum
);

  localparam int SW = WIDTH + BPC;

  // (2^W - 1) + (2^W - 1)(2^BPC - 1) < 2^(W+BPC), so no carry is lost.
  assign sum = SW'(hi) + SW'(a) * SW'(digit);

endmodule

// File: rtl/fpu_mant_mul_seq.sv
// Iterative unsigned mantissa multiplier answering the FPU in_ready/out_ready
// 4-phase handshake; retires BPC multiplier bits per cycle over WIDTH/BPC cycles.
module fpu_mant_mul_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH = SP_MANT_W,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_ready,
  input  logic [WIDTH-1:0]   a_m,
  input  logic [WIDTH-1:0]   b_m,
  output logic [2*WIDTH-1:0] product_out,
  output logic               out_ready
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = $clog2(N + 1);

  if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || (WIDTH % BPC != 0) || (WIDTH <= BPC))
  begin : g_bad_param
    $error("fpu_mant_mul_seq: BPC must be 1, 2 or 4, divide WIDTH and be smaller than WIDTH");
  end

  mul_seq_state_e       state;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     areg;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH+BPC-1:0] sum;
  logic [2*WIDTH-1:0]   next_acc;

  fpu_mul_pp_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .hi    (hi),
    .a     (areg),
    .digit (lo[BPC-1:0]),
    .sum   (sum)
  );

  // {sum, lo} >> BPC: consumed multiplier bits fall off the bottom while the
  // low product bits produced by this step enter lo from the top.
  always_comb begin
    next_acc = {sum, lo[WIDTH-1:BPC]};
  end

  // NOTE: every register below is written with <= so all of them sample the
  // pre-edge values; mixing in blocking writes would make order matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      areg        <= '0;
      cnt         <= '0;
      product_out <= '0;
      out_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready) begin
            hi    <= '0;
            lo    <= b_m;
            areg  <= a_m;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (!in_ready) begin
            state <= IDLE;
          end else begin
            {hi, lo} <= next_acc;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N - 1)) begin
              product_out <= next_acc;
              out_ready   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (!in_ready) begin
            out_ready <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// Directed and random checks of fpu_mant_mul_seq at BPC = 1, 2 and 4 using
// a queue of expected products pushed at request time.
module tb_fpu_mant_mul_seq;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [2:0]            in_ready = '0;
  logic [2:0][23:0]      a_m = '0;
  logic [2:0][23:0]      b_m = '0;
  logic [2:0][47:0]      product_out;
  logic [2:0]            out_ready;

  logic [47:0] sb_q[$];
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fpu_mant_mul_seq #(.WIDTH(24), .BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready[0]), .a_m(a_m[0]), .b_m(b_m[0]),
    .product_out(product_out[0]), .out_ready(out_ready[0]));
  fpu_mant_mul_seq #(.WIDTH(24), .BPC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready[1]), .a_m(a_m[1]), .b_m(b_m[1]),
    .product_out(product_out[1]), .out_ready(out_ready[1]));
  fpu_mant_mul_seq #(.WIDTH(24), .BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_ready(in_ready[2]), .a_m(a_m[2]), .b_m(b_m[2]),
    .product_out(product_out[2]), .out_ready(out_ready[2]));

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int lat_of(input int u);
    return 24 / (1 << u);
  endfunction

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    return 48'(a) * 48'(b);
  endfunction

  // Full 4-phase transaction on unit u; optionally scrambles operands after the start edge.
  task automatic do_op(input int u, input logic [23:0] a, input logic [23:0] b,
                       input logic [47:0] exp, input bit scramble, input string tag);
    int          lat;
    bit          early;
    logic [47:0] want;
    logic [47:0] held;
    sb_q.push_back(exp);
    @(negedge clk);
    a_m[u] = a;
    b_m[u] = b;
    in_ready[u] = 1'b1;
    @(posedge clk);
    lat = 0;
    early = 1'b0;
    for (int k = 1; k <= 64 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (out_ready[u]) lat = k;
      else if (scramble) begin
        a_m[u] = 24'($urandom);
        b_m[u] = 24'($urandom);
      end
    end
    check({tag, " latency"}, 48'(lat), 48'(lat_of(u)));
    want = sb_q.pop_front();
    check({tag, " product"}, product_out[u], want);
    held = product_out[u];
    @(posedge clk);
    #1;
    check({tag, " hold"}, {out_ready[u], product_out[u]}, {1'b1, held});
    @(negedge clk);
    in_ready[u] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " drop"}, {47'd0, out_ready[u]}, 48'd0);
    if (early) check({tag, " early"}, 48'd1, 48'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] p;
    bit          seen;
    logic [23:0] ra;
    logic [23:0] rb;

    // Reset state
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset out_ready u%0d", u), {47'd0, out_ready[u]}, 48'd0);
      check($sformatf("reset product u%0d", u), product_out[u], 48'd0);
    end
    rst_n = 1'b1;

    // Directed products
    do_op(0, 24'h800000, 24'h800000, 48'h4000_0000_0000, 1'b0, "one_x_one");
    do_op(0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 1'b0, "max_bpc1");
    do_op(1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 1'b0, "max_bpc2");
    do_op(2, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 1'b0, "max_bpc4");
    do_op(0, 24'h000000, 24'hABCDEF, 48'h0, 1'b0, "zero_a");
    do_op(0, 24'hC00000, 24'hA00000, 48'h7800_0000_0000, 1'b0, "c_x_a");

    // Abort 10 cycles into CALC
    @(negedge clk);
    a_m[0] = 24'h123456;
    b_m[0] = 24'h654321;
    in_ready[0] = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_ready[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (out_ready[0]) seen = 1'b1;
    end
    check("abort out_ready", {47'd0, seen}, 48'd0);
    check("abort product", product_out[0], 48'h7800_0000_0000);
    do_op(0, 24'h900000, 24'h800000, 48'h4800_0000_0000, 1'b0, "after_abort");

    // Asynchronous reset 5 cycles into CALC
    @(negedge clk);
    a_m[0] = 24'hFFFFFF;
    b_m[0] = 24'h800001;
    in_ready[0] = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_ready[0] = 1'b0;
    #1;
    check("rst out_ready", {47'd0, out_ready[0]}, 48'd0);
    check("rst product", product_out[0], 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst idle", {47'd0, out_ready[0]}, 48'd0);
    do_op(0, 24'h800000, 24'hC00000, 48'h6000_0000_0000, 1'b0, "after_rst");

    // Operands change every cycle after the start edge
    do_op(0, 24'hB504F3, 24'hD1C2E3, ref_mul(24'hB504F3, 24'hD1C2E3), 1'b1, "scramble_bpc1");
    do_op(2, 24'h9ABCDE, 24'hF00001, ref_mul(24'h9ABCDE, 24'hF00001), 1'b1, "scramble_bpc4");

    // Random sweep against the reference model
    for (int i = 0; i < 400; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      do_op(2, ra, rb, ref_mul(ra, rb), i[0], "rand_bpc4");
    end
    for (int i = 0; i < 150; i++) begin
      ra = 24'($urandom) | 24'h800000;
      rb = 24'($urandom) | 24'h800000;
      do_op(1, ra, rb, ref_mul(ra, rb), i[0], "rand_bpc2");
    end
    for (int i = 0; i < 100; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      do_op(0, ra, rb, ref_mul(ra, rb), i[0], "rand_bpc1");
    end

    p = product_out[2];
    check("sb drained", 48'(sb_q.size()), 48'd0);
    check("final idle", {45'd0, out_ready}, 48'd0);
    check("final product hold", product_out[2], p);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
